// File: rtl/os_inst_sequencer.sv
// Instruction sequencer for the output-stationary core: walks weight fill, activation
// fill, execute and drain for every input channel, then writes OFIFO results to pmem.
module os_inst_sequencer #(
  parameter int unsigned LEN_KIJ   = 9,
  parameter int unsigned LEN_NIJ   = 9,
  parameter int unsigned LEN_ONIJ  = 8,
  parameter int unsigned LEN_IC    = 3,
  parameter int unsigned DRAIN_CYC = 13,
  parameter int unsigned W_BASE    = 1024,
  parameter int unsigned A_BASE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [35:0] inst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  ic_idx
);

  localparam int unsigned CW  = 8;
  localparam int unsigned AW  = 11;
  localparam int unsigned ICW = 2;

  localparam int unsigned B_OUT_EN   = 35;
  localparam int unsigned B_MODE     = 34;
  localparam int unsigned B_CEN_PMEM = 32;
  localparam int unsigned B_WEN_PMEM = 31;
  localparam int unsigned B_CEN_XMEM = 19;
  localparam int unsigned B_WEN_XMEM = 18;
  localparam int unsigned B_OFIFO_RD = 6;
  localparam int unsigned B_IFIFO_WR = 5;
  localparam int unsigned B_IFIFO_RD = 4;
  localparam int unsigned B_L0_RD    = 3;
  localparam int unsigned B_L0_WR    = 2;
  localparam int unsigned B_EXECUTE  = 1;

  localparam logic [35:0] IDLE_INST = (36'(1) << B_MODE) | (36'(1) << B_CEN_PMEM) |
                                      (36'(1) << B_WEN_PMEM) | (36'(1) << B_CEN_XMEM) |
                                      (36'(1) << B_WEN_XMEM);

  typedef enum logic [3:0] {
    S_IDLE, S_W_FILL, S_GAP, S_A_FILL, S_EXEC, S_TAIL, S_DRAIN, S_OUT_PRE, S_OUT_WR, S_DONE
  } state_t;

  state_t           state, nxt_state;
  logic [CW-1:0]    cnt, nxt_cnt;
  logic [ICW-1:0]   ic, nxt_ic;
  logic [35:0]      inst_d;

  // Next state / phase counter / channel index.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = cnt + CW'(1);
    nxt_ic    = ic;
    case (state)
      S_IDLE: begin
        nxt_cnt = '0;
        nxt_ic  = '0;
        if (start) nxt_state = S_W_FILL;
      end
      S_W_FILL:  if (cnt == CW'(LEN_KIJ))       begin nxt_state = S_GAP;    nxt_cnt = '0; end
      S_GAP:     if (cnt == CW'(1))             begin nxt_state = S_A_FILL; nxt_cnt = '0; end
      S_A_FILL:  if (cnt == CW'(LEN_NIJ))       begin nxt_state = S_EXEC;   nxt_cnt = '0; end
      S_EXEC:    if (cnt == CW'(LEN_NIJ - 1))   begin nxt_state = S_TAIL;   nxt_cnt = '0; end
      S_TAIL:    if (cnt == CW'(1))             begin nxt_state = S_DRAIN;  nxt_cnt = '0; end
      S_DRAIN: begin
        if (cnt == CW'(DRAIN_CYC - 1)) begin
          nxt_cnt = '0;
          if (ic < ICW'(LEN_IC - 1)) begin
            nxt_state = S_W_FILL;
            nxt_ic    = ic + ICW'(1);
          end else begin
            nxt_state = S_OUT_PRE;
          end
        end
      end
      S_OUT_PRE: begin nxt_state = S_OUT_WR; nxt_cnt = '0; end
      S_OUT_WR:  if (cnt == CW'(LEN_ONIJ - 1))  begin nxt_state = S_DONE;   nxt_cnt = '0; end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
        nxt_ic    = '0;
      end
      default: begin
        nxt_state = S_IDLE;
        nxt_cnt   = '0;
        nxt_ic    = '0;
      end
    endcase
  end

  // Instruction for the upcoming cycle; SRAM read latency shifts the write strobes by one.
  always_comb begin
    inst_d = IDLE_INST;
    case (nxt_state)
      S_W_FILL: begin
        if (nxt_cnt < CW'(LEN_KIJ)) begin
          inst_d[B_CEN_XMEM] = 1'b0;
          inst_d[17:7] = AW'(W_BASE) + AW'(nxt_ic) * AW'(LEN_KIJ) + AW'(nxt_cnt);
        end
        if (nxt_cnt != '0) inst_d[B_IFIFO_WR] = 1'b1;
      end
      S_A_FILL: begin
        if (nxt_cnt < CW'(LEN_NIJ)) begin
          inst_d[B_CEN_XMEM] = 1'b0;
          inst_d[17:7] = AW'(A_BASE) + AW'(nxt_ic) * AW'(LEN_NIJ) + AW'(nxt_cnt);
        end
        if (nxt_cnt != '0) inst_d[B_L0_WR] = 1'b1;
      end
      S_EXEC: begin
        inst_d[B_IFIFO_RD] = 1'b1;
        inst_d[B_L0_RD]    = 1'b1;
        inst_d[B_EXECUTE]  = 1'b1;
      end
      S_TAIL: begin
        inst_d[B_IFIFO_RD] = 1'b1;
        inst_d[B_L0_RD]    = 1'b1;
      end
      S_OUT_PRE: begin
        inst_d[B_OUT_EN]   = 1'b1;
        inst_d[B_OFIFO_RD] = 1'b1;
      end
      S_OUT_WR: begin
        inst_d[B_OUT_EN]   = 1'b1;
        inst_d[B_OFIFO_RD] = 1'b1;
        inst_d[B_CEN_PMEM] = 1'b0;
        inst_d[B_WEN_PMEM] = 1'b0;
        inst_d[30:20]      = AW'(LEN_ONIJ - 1) - AW'(nxt_cnt);
      end
      default: inst_d = IDLE_INST;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      ic     <= '0;
      inst   <= IDLE_INST;
      busy   <= 1'b0;
      done   <= 1'b0;
      ic_idx <= '0;
    end else begin
      state  <= nxt_state;
      cnt    <= nxt_cnt;
      ic     <= nxt_ic;
      inst   <= inst_d;
      busy   <= (nxt_state != S_IDLE) && (nxt_state != S_DONE);
      done   <= (nxt_state == S_DONE);
      ic_idx <= nxt_ic;
    end
  end

endmodule

// File: tb/tb_os_inst_sequencer.sv
// Directed bench for os_inst_sequencer: captures a per-cycle trace after each start
// and checks it against hand-derived schedule values.
module tb_os_inst_sequencer;

  localparam logic [35:0] IDLE_INST = 36'h5_800C_0000;
  localparam int P = 46;
  localparam int TRN = 320;

  logic        clk;
  logic        reset;
  logic        start;
  logic [35:0] inst;
  logic        busy;
  logic        done;
  logic [1:0]  ic_idx;

  int checks;
  int failures;

  logic [35:0] tr_inst [0:TRN-1];
  logic        tr_busy [0:TRN-1];
  logic        tr_done [0:TRN-1];
  logic [1:0]  tr_ic   [0:TRN-1];

  os_inst_sequencer dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .inst   (inst),
    .busy   (busy),
    .done   (done),
    .ic_idx (ic_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Raise start so the next edge is edge N; returns #1 after edge N (index 0).
  task automatic launch();
    start = 1'b1;
    @(posedge clk); #1;
  endtask

  // Records n cycles; start/reset listed indices are driven during that cycle.
  task automatic capture(input int n, input int s1, input int s2, input int s3, input int rst_at);
    for (int i = 0; i < n; i++) begin
      tr_inst[i] = inst;
      tr_busy[i] = busy;
      tr_done[i] = done;
      tr_ic[i]   = ic_idx;
      start = (i == s1) || (i == s2) || (i == s3);
      reset = (i == rst_at);
      @(posedge clk); #1;
    end
    start = 1'b0;
    reset = 1'b0;
  endtask

  function automatic int count_bit(input int b, input int lo, input int hi);
    int c = 0;
    for (int i = lo; i < hi; i++) if (tr_inst[i][b]) c++;
    return c;
  endfunction

  function automatic int first_done(input int lo, input int hi);
    for (int i = lo; i < hi; i++) if (tr_done[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (inst !== IDLE_INST) begin failures++; $display("FAIL reset_inst got=%h exp=%h", inst, IDLE_INST); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (ic_idx !== 2'd0) begin failures++; $display("FAIL reset_ic got=%0d exp=0", ic_idx); end
  endtask

  task automatic test_full_sequence();
    int k;
    int bad;
    launch();
    capture(150, -1, -1, -1, -1);
    for (int c = 0; c < 3; c++) begin
      checks++; if (count_bit(5, c*P, c*P+P) !== 9) begin failures++; $display("FAIL ififo_wr_count ch=%0d got=%0d exp=9", c, count_bit(5, c*P, c*P+P)); end
      checks++; if (count_bit(2, c*P, c*P+P) !== 9) begin failures++; $display("FAIL l0_wr_count ch=%0d got=%0d exp=9", c, count_bit(2, c*P, c*P+P)); end
      k = 0;
      for (int i = c*P; i < c*P+P; i++) begin
        if (tr_inst[i][19] == 1'b0) begin
          checks++;
          if (k < 9) begin
            if (tr_inst[i][17:7] !== 11'(1024 + c*9 + k)) begin failures++; $display("FAIL w_addr ch=%0d idx=%0d got=%0d exp=%0d", c, i, tr_inst[i][17:7], 1024 + c*9 + k); end
          end else begin
            if (tr_inst[i][17:7] !== 11'(c*9 + k - 9)) begin failures++; $display("FAIL a_addr ch=%0d idx=%0d got=%0d exp=%0d", c, i, tr_inst[i][17:7], c*9 + k - 9); end
          end
          k++;
        end
      end
      checks++; if (k !== 18) begin failures++; $display("FAIL xmem_reads ch=%0d got=%0d exp=18", c, k); end
    end
    checks++; if (first_done(0, 150) !== 147) begin failures++; $display("FAIL done_index got=%0d exp=147", first_done(0, 150)); end
    checks++; if (tr_done[148] !== 1'b0) begin failures++; $display("FAIL done_width got=%b exp=0", tr_done[148]); end
    checks++; if (tr_inst[147] !== IDLE_INST) begin failures++; $display("FAIL done_inst got=%h exp=%h", tr_inst[147], IDLE_INST); end
    checks++; if (tr_busy[0] !== 1'b1 || tr_busy[146] !== 1'b1) begin failures++; $display("FAIL busy_active got=%b%b exp=11", tr_busy[0], tr_busy[146]); end
    checks++; if (tr_busy[147] !== 1'b0) begin failures++; $display("FAIL busy_done got=%b exp=0", tr_busy[147]); end
    checks++; if (tr_ic[45] !== 2'd0 || tr_ic[46] !== 2'd1 || tr_ic[91] !== 2'd1 || tr_ic[92] !== 2'd2) begin
      failures++; $display("FAIL ic_boundary got=%0d,%0d,%0d,%0d exp=0,1,1,2", tr_ic[45], tr_ic[46], tr_ic[91], tr_ic[92]);
    end
    bad = 0;
    for (int i = 0; i < 150; i++) if (tr_inst[i][34] !== 1'b1 || tr_inst[i][33] !== 1'b0 || tr_inst[i][0] !== 1'b0 || tr_inst[i][18] !== 1'b1) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL fixed_bits violations got=%0d exp=0", bad); end
  endtask

  // Uses the trace left by test_full_sequence.
  task automatic test_exec_window();
    int bad;
    for (int c = 0; c < 3; c++) begin
      checks++; if (count_bit(1, c*P, c*P+P) !== 9) begin failures++; $display("FAIL exec_count ch=%0d got=%0d exp=9", c, count_bit(1, c*P, c*P+P)); end
      checks++; if (tr_inst[c*P+22][4:1] !== 4'b1101 || tr_inst[c*P+30][4:1] !== 4'b1101 || tr_inst[c*P+21][1] !== 1'b0) begin
        failures++; $display("FAIL exec_edges ch=%0d got=%b,%b exp=1101,1101", c, tr_inst[c*P+22][4:1], tr_inst[c*P+30][4:1]);
      end
      checks++; if (tr_inst[c*P+31][4:1] !== 4'b1100 || tr_inst[c*P+32][4:1] !== 4'b1100 || tr_inst[c*P+33][4:1] !== 4'b0000) begin
        failures++; $display("FAIL tail ch=%0d got=%b,%b,%b exp=1100,1100,0000", c, tr_inst[c*P+31][4:1], tr_inst[c*P+32][4:1], tr_inst[c*P+33][4:1]);
      end
    end
    bad = 0;
    for (int i = 0; i < 150; i++) if ((tr_inst[i][5] | tr_inst[i][2]) && (tr_inst[i][4] | tr_inst[i][3])) bad++;
    checks++; if (bad !== 0) begin failures++; $display("FAIL rd_during_fill got=%0d exp=0", bad); end
  endtask

  // Uses the trace left by test_full_sequence.
  task automatic test_write_back();
    checks++; if (tr_inst[137][35] !== 1'b0) begin failures++; $display("FAIL out_en_early got=%b exp=0", tr_inst[137][35]); end
    checks++; if (tr_inst[138][35] !== 1'b1 || tr_inst[138][6] !== 1'b1 || tr_inst[138][32:31] !== 2'b11) begin
      failures++; $display("FAIL out_pre got=%h exp out_en,ofifo_rd set, pmem off", tr_inst[138]);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (tr_inst[139+k][35] !== 1'b1 || tr_inst[139+k][6] !== 1'b1 || tr_inst[139+k][32:31] !== 2'b00 || tr_inst[139+k][30:20] !== 11'(7 - k)) begin
        failures++; $display("FAIL pmem_wr idx=%0d got_addr=%0d got_inst=%h exp_addr=%0d", 139+k, tr_inst[139+k][30:20], tr_inst[139+k], 7 - k);
      end
    end
  endtask

  task automatic test_start_while_busy();
    launch();
    capture(300, 20, 147, 148, -1);
    checks++; if (tr_ic[46] !== 2'd1) begin failures++; $display("FAIL start_busy_ic got=%0d exp=1", tr_ic[46]); end
    checks++; if (first_done(0, 148) !== 147) begin failures++; $display("FAIL start_busy_done got=%0d exp=147", first_done(0, 148)); end
    checks++; if (tr_inst[148] !== IDLE_INST || tr_busy[148] !== 1'b0) begin failures++; $display("FAIL start_in_done got=%h busy=%b exp=%h busy=0", tr_inst[148], tr_busy[148], IDLE_INST); end
    checks++; if (tr_busy[149] !== 1'b1 || tr_ic[149] !== 2'd0 || tr_inst[149][19] !== 1'b0 || tr_inst[149][17:7] !== 11'd1024) begin
      failures++; $display("FAIL restart got busy=%b ic=%0d addr=%0d exp busy=1 ic=0 addr=1024", tr_busy[149], tr_ic[149], tr_inst[149][17:7]);
    end
    checks++; if (first_done(149, 300) !== 296) begin failures++; $display("FAIL restart_done got=%0d exp=296", first_done(149, 300)); end
  endtask

  task automatic test_mid_reset();
    launch();
    capture(63, -1, -1, -1, 60);
    checks++; if (tr_busy[60] !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", tr_busy[60]); end
    checks++; if (tr_inst[61] !== IDLE_INST || tr_busy[61] !== 1'b0 || tr_ic[61] !== 2'd0) begin
      failures++; $display("FAIL mid_reset got=%h busy=%b ic=%0d exp=%h busy=0 ic=0", tr_inst[61], tr_busy[61], tr_ic[61], IDLE_INST);
    end
    checks++; if (tr_inst[62] !== IDLE_INST) begin failures++; $display("FAIL no_resume got=%h exp=%h", tr_inst[62], IDLE_INST); end
    repeat (2) @(posedge clk);
    #1;
    launch();
    capture(150, -1, -1, -1, -1);
    checks++; if (tr_inst[0][19] !== 1'b0 || tr_inst[0][17:7] !== 11'd1024 || tr_ic[0] !== 2'd0) begin
      failures++; $display("FAIL rerun_first got_addr=%0d ic=%0d exp_addr=1024 ic=0", tr_inst[0][17:7], tr_ic[0]);
    end
    checks++; if (count_bit(5, 0, P) !== 9 || count_bit(2, 0, P) !== 9) begin failures++; $display("FAIL rerun_fills got=%0d,%0d exp=9,9", count_bit(5, 0, P), count_bit(2, 0, P)); end
    checks++; if (tr_ic[92] !== 2'd2) begin failures++; $display("FAIL rerun_ic got=%0d exp=2", tr_ic[92]); end
    checks++; if (first_done(0, 150) !== 147) begin failures++; $display("FAIL rerun_done got=%0d exp=147", first_done(0, 150)); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    start    = 1'b0;
    test_reset();
    test_full_sequence();
    test_exec_window();
    test_write_back();
    repeat (3) @(posedge clk);
    #1;
    test_start_while_busy();
    repeat (3) @(posedge clk);
    #1;
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
